// File: rtl/seq_divider8.sv
// ---------------------------------------------------------------------------
// seq_divider8 : 8-bit sequential restoring divider, one quotient bit per
// clock, MSB first.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   operation request, sampled only while idle
//   Dividend   in   [7:0] numerator, captured when start is accepted
//   Divisor    in   [7:0] denominator, captured when start is accepted
//   SignedOp   in   two's complement operation request
//                   (only present with SEQ_DIV_SIGNED_EN)
//   Quotient   out  [7:0] registered quotient
//   Remainder  out  [7:0] registered remainder
//   busy       out  high while running and during the done cycle
//   done       out  one-cycle pulse, results valid
//   DivByZero  out  last accepted operation had Divisor == 0
//
// Build option
//   SEQ_DIV_SIGNED_EN : adds SignedOp and sign handling. Undefined, the
//                       block is unsigned only.
//
// Timing: a normal operation spends 8 cycles in RUN and then 1 in DONE;
// a zero divisor goes straight from IDLE to DONE.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one restoring step per cycle, cnt_q = 0..7
// DONE  | results registered, done pulse, back to IDLE
// ---------------------------------------------------------------------------
module seq_divider8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] Dividend,
  input  logic [7:0] Divisor,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic       SignedOp,
`endif
  output logic [7:0] Quotient,
  output logic [7:0] Remainder,
  output logic       busy,
  output logic       done,
  output logic       DivByZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [7:0] dvs_q, dvs_d;
  logic [7:0] rem_q, rem_d;   // partial remainder
  logic [7:0] quo_q, quo_d;
  logic [7:0] rmd_q, rmd_d;
  logic       dbz_q, dbz_d;

`ifdef SEQ_DIV_SIGNED_EN
  logic       qneg_q, qneg_d;
  logic       rneg_q, rneg_d;

  function automatic logic [7:0] abs8(input logic [7:0] x);
    // -128 maps to 8'h80, which is +128 as an unsigned magnitude
    return x[7] ? (~x + 8'd1) : x;
  endfunction
`endif

  logic [8:0] shifted;
  logic       step_ok;
  logic [7:0] rem_next;
  logic [7:0] quo_next;
  logic [7:0] q_fin;
  logic [7:0] r_fin;

  always_comb begin
    shifted  = {rem_q, dvd_q[7]};
    // 9-bit trial subtract: non-negative exactly when shifted >= divisor.
    // The partial remainder stays below the divisor, so a kept difference
    // always fits in 8 bits.
    step_ok  = (shifted >= {1'b0, dvs_q});
    rem_next = step_ok ? (shifted[7:0] - dvs_q) : shifted[7:0];
    quo_next = {dvd_q[6:0], step_ok};
`ifdef SEQ_DIV_SIGNED_EN
    q_fin    = qneg_q ? (~quo_next + 8'd1) : quo_next;
    r_fin    = rneg_q ? (~rem_next + 8'd1) : rem_next;
`else
    q_fin    = quo_next;
    r_fin    = rem_next;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (Divisor == 8'd0) begin
            quo_d   = 8'hFF;
            rmd_d   = Dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
`endif
          end else begin
`ifdef SEQ_DIV_SIGNED_EN
            dvd_d   = SignedOp ? abs8(Dividend) : Dividend;
            dvs_d   = SignedOp ? abs8(Divisor)  : Divisor;
            qneg_d  = SignedOp & (Dividend[7] ^ Divisor[7]);
            rneg_d  = SignedOp & Dividend[7];
`else
            dvd_d   = Dividend;
            dvs_d   = Divisor;
`endif
            rem_d   = 8'd0;
            cnt_d   = 3'd0;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        dvd_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          quo_d   = q_fin;
          rmd_d   = r_fin;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      dvd_q   <= 8'd0;
      dvs_q   <= 8'd0;
      rem_q   <= 8'd0;
      quo_q   <= 8'd0;
      rmd_q   <= 8'd0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign Quotient  = quo_q;
  assign Remainder = rmd_q;
  assign DivByZero = dbz_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
